// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty slew limiter and related PWM blocks.
package pwm_pkg;

    // Default duty width, matching the PWM core compare register.
    localparam int PWM_DUTY_W_DFLT = 24;

    // Working width for the step helper. It is wide enough that any duty width
    // up to 63 bits can be zero-extended into it with no overflow on +/- step.
    localparam int PWM_CALC_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPDATE    = 2'd1,
        PUSH      = 2'd2,
        WAIT_TICK = 2'd3
    } pwm_state_e;

    // One saturating step of cur toward tgt. A zero step means jump straight
    // to the target. Working on the magnitude of the difference avoids signed
    // arithmetic; the result never overshoots tgt and never wraps.
    function automatic logic [PWM_CALC_W-1:0] slew_step(
        input logic [PWM_CALC_W-1:0] cur,
        input logic [PWM_CALC_W-1:0] tgt,
        input logic [PWM_CALC_W-1:0] step
    );
        logic [PWM_CALC_W-1:0] mag;
        mag = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if ((step == '0) || (mag <= step))
            return tgt;
        else if (tgt > cur)
            return cur + step;
        else
            return cur - step;
    endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Loadable down-counter used as a tick prescaler. zero_o flags the cycle in
// which the running counter lands on (or already sits at) zero, so a caller
// that loads N-1 and runs the counter sees the flag on the (N-1)th enabled
// cycle and can act on the following edge.
module pwm_tick_prescaler #(
    parameter int C_DIV_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [C_DIV_WIDTH-1:0] load_val_i,
    input  logic                   en_i,
    output logic                   zero_o
);

    logic [C_DIV_WIDTH-1:0] cnt_q;
    logic [C_DIV_WIDTH-1:0] cnt_d;

    // Load has priority over counting; the counter holds at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - C_DIV_WIDTH'(1);
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q <= C_DIV_WIDTH'(1));

endmodule

// File: rtl/pwm_duty_slew.sv
// Duty slew-rate limiter in front of the PWM core duty input. A requested
// target is approached in steps of at most STEP, one step per prescaled tick,
// each intermediate value offered on a DUTY valid/ready handshake.
// Optional build macro PWM_SLEW_CLAMP_EN adds C_DUTY_MAX target clamping and
// the sticky CLAMPED output.
module pwm_duty_slew
    import pwm_pkg::*;
#(
    parameter int C_DUTY_WIDTH = PWM_DUTY_W_DFLT,
    parameter int C_TICK_DIV   = 1024,
    parameter int C_DIV_WIDTH  = 16
`ifdef PWM_SLEW_CLAMP_EN
    ,
    parameter logic [C_DUTY_WIDTH-1:0] C_DUTY_MAX = '1
`endif
) (
    input  logic                    PWM_CLK,
    input  logic                    PWM_RST,
    input  logic [C_DUTY_WIDTH-1:0] TARGET,
    input  logic                    TARGET_VALID,
    output logic                    TARGET_READY,
    input  logic [C_DUTY_WIDTH-1:0] STEP,
    output logic [C_DUTY_WIDTH-1:0] DUTY,
    output logic                    DUTY_VALID,
    input  logic                    DUTY_READY,
    output logic                    BUSY
`ifdef PWM_SLEW_CLAMP_EN
    ,
    output logic                    CLAMPED
`endif
);

    localparam logic [C_DIV_WIDTH-1:0] TICK_RELOAD = C_DIV_WIDTH'(C_TICK_DIV - 1);

    pwm_state_e              state_q,  state_d;
    logic [C_DUTY_WIDTH-1:0] duty_q,   duty_d;
    logic [C_DUTY_WIDTH-1:0] target_q, target_d;
    logic [C_DUTY_WIDTH-1:0] step_q,   step_d;
    logic [C_DUTY_WIDTH-1:0] tgt_in;
    logic                    accept;
    logic                    psc_load;
    logic                    psc_en;
    logic                    psc_zero;

`ifdef PWM_SLEW_CLAMP_EN
    logic clamp_hit;
    logic clamped_q, clamped_d;

    // Over-range requests are latched as the ceiling value.
    assign clamp_hit = (TARGET > C_DUTY_MAX);
    assign tgt_in    = clamp_hit ? C_DUTY_MAX : TARGET;

    // Sticky flag: each accepted target decides whether it stays set.
    always_comb begin
        clamped_d = clamped_q;
        if (accept)
            clamped_d = clamp_hit;
    end

    // Clamp flag register.
    always_ff @(posedge PWM_CLK) begin
        if (PWM_RST)
            clamped_q <= 1'b0;
        else
            clamped_q <= clamped_d;
    end

    assign CLAMPED = clamped_q;
`else
    assign tgt_in = TARGET;
`endif

    // New targets are taken when idle or between ticks (retarget), never
    // while a beat is being offered, and never during reset.
    assign TARGET_READY = !PWM_RST && ((state_q == IDLE) || (state_q == WAIT_TICK));
    assign accept       = TARGET_VALID && TARGET_READY;
    assign psc_en       = (state_q == WAIT_TICK);

    pwm_tick_prescaler #(
        .C_DIV_WIDTH (C_DIV_WIDTH)
    ) u_prescaler (
        .clk_i      (PWM_CLK),
        .rst_i      (PWM_RST),
        .load_i     (psc_load),
        .load_val_i (TICK_RELOAD),
        .en_i       (psc_en),
        .zero_o     (psc_zero)
    );

    // Next-state logic: accept/retarget, step update, beat handshake, tick wait.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        psc_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = tgt_in;
                    step_d   = STEP;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                duty_d  = C_DUTY_WIDTH'(slew_step(PWM_CALC_W'(duty_q),
                                                  PWM_CALC_W'(target_q),
                                                  PWM_CALC_W'(step_q)));
                state_d = PUSH;
            end
            PUSH: begin
                if (DUTY_READY) begin
                    if (duty_q == target_q) begin
                        state_d = IDLE;
                    end else begin
                        psc_load = 1'b1;
                        state_d  = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                // A retarget wins over a tick landing in the same cycle.
                if (accept) begin
                    target_d = tgt_in;
                    step_d   = STEP;
                    state_d  = UPDATE;
                end else if (psc_zero) begin
                    state_d = UPDATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, duty and latched request registers.
    always_ff @(posedge PWM_CLK) begin
        if (PWM_RST) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
        end
    end

    assign DUTY       = duty_q;
    assign DUTY_VALID = (state_q == PUSH);
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Scoreboard bench for pwm_duty_slew with C_TICK_DIV=4. Stimulus pushes the
// expected beats (value and cycle gap from the previous accept/handshake)
// into a queue; a negedge monitor pops and compares on every DUTY handshake.
module tb_pwm_duty_slew;

    localparam int W   = 24;
    localparam int DIV = 4;
`ifdef PWM_SLEW_CLAMP_EN
    localparam logic [W-1:0] DMAX = 24'h800000;
`else
    localparam logic [W-1:0] DMAX = 24'hFFFFFF;
`endif

    logic         PWM_CLK = 1'b0;
    logic         PWM_RST;
    logic [W-1:0] TARGET;
    logic         TARGET_VALID;
    logic         TARGET_READY;
    logic [W-1:0] STEP;
    logic [W-1:0] DUTY;
    logic         DUTY_VALID;
    logic         DUTY_READY;
    logic         BUSY;
`ifdef PWM_SLEW_CLAMP_EN
    logic         CLAMPED;
`endif

    pwm_duty_slew #(
        .C_DUTY_WIDTH (W),
        .C_TICK_DIV   (DIV),
        .C_DIV_WIDTH  (16)
`ifdef PWM_SLEW_CLAMP_EN
        , .C_DUTY_MAX (DMAX)
`endif
    ) dut (
        .PWM_CLK      (PWM_CLK),
        .PWM_RST      (PWM_RST),
        .TARGET       (TARGET),
        .TARGET_VALID (TARGET_VALID),
        .TARGET_READY (TARGET_READY),
        .STEP         (STEP),
        .DUTY         (DUTY),
        .DUTY_VALID   (DUTY_VALID),
        .DUTY_READY   (DUTY_READY),
        .BUSY         (BUSY)
`ifdef PWM_SLEW_CLAMP_EN
        , .CLAMPED    (CLAMPED)
`endif
    );

    always #5 PWM_CLK = ~PWM_CLK;

    typedef struct {
        logic [W-1:0] duty;
        int           gap;   // -1: timing not checked
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_total  = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           last_evt = 0;
    logic [W-1:0] m_cur    = '0;

    always @(posedge PWM_CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every DUTY handshake must match the head of the scoreboard.
    always @(negedge PWM_CLK) begin
        if (!PWM_RST && DUTY_VALID && DUTY_READY) begin
            if (q.size() == 0) begin
                n_total = n_total + 1;
                $display("FAIL unexpected_beat: got DUTY 0x%0h expected no beat", DUTY);
            end else begin
                mon_e = q.pop_front();
                chk("beat_duty", 32'(DUTY), 32'(mon_e.duty));
                if (mon_e.gap >= 0)
                    chk("beat_gap", 32'(cyc - last_evt), 32'(mon_e.gap));
            end
            last_evt = cyc;
        end
    end

    task automatic enq(input logic [W-1:0] d, input int gap);
        exp_t e;
        e.duty = d;
        e.gap  = gap;
        q.push_back(e);
    endtask

    // Reference ramp: enqueue every beat from m_cur to the (clamped) target.
    task automatic model_ramp(input logic [W-1:0] tgt, input logic [W-1:0] step, input int first_gap);
        logic [W-1:0] t;
        logic [W-1:0] mag;
        int           g;
        t = (tgt > DMAX) ? DMAX : tgt;
        g = first_gap;
        do begin
            mag = (t >= m_cur) ? t - m_cur : m_cur - t;
            if (step == 0 || mag <= step) m_cur = t;
            else if (t > m_cur)           m_cur = m_cur + step;
            else                          m_cur = m_cur - step;
            enq(m_cur, g);
            g = DIV + 1;
        end while (m_cur != t);
    endtask

    task automatic send_target(input logic [W-1:0] t, input logic [W-1:0] s);
        bit ok;
        ok = 0;
        @(posedge PWM_CLK); #1;
        TARGET = t; STEP = s; TARGET_VALID = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge PWM_CLK);
            if (TARGET_READY) begin
                ok = 1;
                last_evt = cyc;
            end
        end
        if (!ok) begin
            n_total = n_total + 1;
            $display("FAIL accept_timeout: got no TARGET_READY expected accept");
        end
        @(posedge PWM_CLK); #1;
        TARGET_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge PWM_CLK);
        if (q.size() != 0) begin
            n_total = n_total + 1;
            $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, q.size());
            q.delete();
        end
        @(posedge PWM_CLK);
        @(negedge PWM_CLK);
        chk({name, "_busy_after"}, 32'(BUSY), 32'h0);
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge PWM_CLK);
            if (DUTY_VALID) ok = 1;
        end
        if (!ok) begin
            n_total = n_total + 1;
            $display("FAIL %s_valid_timeout: got DUTY_VALID 0 expected 1", name);
        end
    endtask

    initial begin
        bit seen;
        PWM_RST = 1'b1; TARGET = '0; STEP = '0; TARGET_VALID = 1'b0; DUTY_READY = 1'b1;

        // Reset state
        repeat (3) @(posedge PWM_CLK);
        @(negedge PWM_CLK);
        chk("rst_ready",  32'(TARGET_READY), 32'h0);
        chk("rst_duty",   32'(DUTY),         32'h0);
        chk("rst_valid",  32'(DUTY_VALID),   32'h0);
        chk("rst_busy",   32'(BUSY),         32'h0);
`ifdef PWM_SLEW_CLAMP_EN
        chk("rst_clamped", 32'(CLAMPED), 32'h0);
`endif
        @(posedge PWM_CLK); #1;
        PWM_RST = 1'b0;
        @(negedge PWM_CLK);
        chk("post_rst_ready", 32'(TARGET_READY), 32'h1);

        // Ramp up from zero, 0x100000 per tick
        model_ramp(24'hC00000, 24'h100000, 2);
        send_target(24'hC00000, 24'h100000);
        wait_drain("ramp_up");
        chk("ramp_up_final", 32'(DUTY), 32'((24'hC00000 > DMAX) ? DMAX : 24'hC00000));

        // Ramp down with a partial final step
        model_ramp(24'h050000, 24'h300000, 2);
        send_target(24'h050000, 24'h300000);
        wait_drain("ramp_down");
        chk("ramp_down_final", 32'(DUTY), 32'h050000);

        // STEP=0 jumps in a single beat
        model_ramp(24'hABCDEF, 24'h0, 2);
        send_target(24'hABCDEF, 24'h0);
        wait_drain("jump");
`ifdef PWM_SLEW_CLAMP_EN
        chk("jump_final", 32'(DUTY), 32'h800000);
`else
        chk("jump_final", 32'(DUTY), 32'hABCDEF);
`endif

        // Target equal to current: one unchanged beat
        model_ramp(24'hABCDEF, 24'h10, 2);
        send_target(24'hABCDEF, 24'h10);
        wait_drain("equal");

        // Backpressure on the first beat of a ramp to zero
        DUTY_READY = 1'b0;
        model_ramp(24'h0, 24'h400000, 2);
        q[0].gap = -1;
        send_target(24'h0, 24'h400000);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            chk("bp_duty_stable", 32'(DUTY),         32'(q[0].duty));
            chk("bp_valid_held",  32'(DUTY_VALID),   32'h1);
            chk("bp_no_retarget", 32'(TARGET_READY), 32'h0);
            @(negedge PWM_CLK);
        end
        @(posedge PWM_CLK); #1;
        DUTY_READY = 1'b1;
        wait_drain("bp");

        // Retarget during the tick wait after the 0x300000 beat
        enq(24'h100000, 2);
        enq(24'h200000, DIV + 1);
        enq(24'h300000, DIV + 1);
        send_target(24'hC00000, 24'h100000);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge PWM_CLK);
            if (DUTY_VALID && DUTY_READY && DUTY == 24'h300000) seen = 1;
        end
        chk("retarget_reached_0x300000", 32'(seen), 32'h1);
        enq(24'h200000, 2);
        enq(24'h100000, DIV + 1);
        m_cur = 24'h100000;
        send_target(24'h100000, 24'h100000);
        wait_drain("retarget");
`ifdef PWM_SLEW_CLAMP_EN
        chk("retarget_clamped_cleared", 32'(CLAMPED), 32'h0);
`endif

        // Reset while a beat is pending
        DUTY_READY = 1'b0;
        send_target(24'hC00000, 24'h100000);
        wait_valid("mid_rst");
        chk("mid_rst_pending_duty", 32'(DUTY), 32'h200000);
        @(posedge PWM_CLK); #1;
        PWM_RST = 1'b1;
        @(negedge PWM_CLK);
        chk("mid_rst_ready_low", 32'(TARGET_READY), 32'h0);
        @(posedge PWM_CLK); #1;
        chk("mid_rst_duty",  32'(DUTY),       32'h0);
        chk("mid_rst_valid", 32'(DUTY_VALID), 32'h0);
        chk("mid_rst_busy",  32'(BUSY),       32'h0);
        PWM_RST = 1'b0;
        DUTY_READY = 1'b1;
        m_cur = '0;
        repeat (6) @(negedge PWM_CLK);
        chk("mid_rst_no_beat", 32'(DUTY_VALID), 32'h0);

        // Full-scale jump up, then full-scale single step back down
        model_ramp(24'hFFFFFF, 24'h0, 2);
        send_target(24'hFFFFFF, 24'h0);
`ifdef PWM_SLEW_CLAMP_EN
        chk("clamp_set", 32'(CLAMPED), 32'h1);
`endif
        wait_drain("full_up");
        model_ramp(24'h0, 24'hFFFFFF, 2);
        send_target(24'h0, 24'hFFFFFF);
`ifdef PWM_SLEW_CLAMP_EN
        chk("clamp_cleared", 32'(CLAMPED), 32'h0);
`endif
        wait_drain("full_down");
        chk("full_down_final", 32'(DUTY), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
